// File: rtl/pipe_pkg.sv
// Shared definitions for the registered valid/ready pipeline chain:
// stage state encoding, occupancy-count width helper and default reset value.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam logic [31:0] DEFAULT_RESET_VALUE = '0;

  // Occupancy ranges over 0..2*num_stages inclusive.
  function automatic int unsigned cnt_width(input int unsigned num_stages);
    return $clog2(2 * num_stages + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One skid-buffer stage: main + skid entry, ready driven straight from a flop
// so there is no combinational path from downstream ready to upstream ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  stage_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q;
  logic                  in_fire, out_fire;

  assign o_valid  = (state_q != ST_EMPTY);
  assign o_data   = main_q;
  assign o_ready  = ready_q;
  assign in_fire  = i_valid && ready_q;
  assign out_fire = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_HALF;
          main_d  = i_data;
        end
      end
      ST_HALF: begin
        if (in_fire && out_fire) begin
          main_d = i_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = i_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end
  end

  // Ready is registered from the next state so it mirrors !skid_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// NUM_STAGES skid stages in series with a registered occupancy counter;
// flush clears every in-flight word on the next edge.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(DEFAULT_RESET_VALUE),
  parameter int unsigned           CNT_WIDTH   = cnt_width(NUM_STAGES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(2 * NUM_STAGES);

  logic                  chain_valid [NUM_STAGES+1];
  logic                  chain_ready [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] chain_data  [NUM_STAGES+1];
  logic                  up_fire, dn_fire;
  logic [CNT_WIDTH-1:0]  count_q;

  assign chain_valid[0]          = i_valid;
  assign chain_data[0]           = i_data;
  assign o_ready                 = chain_ready[0];
  assign chain_ready[NUM_STAGES] = i_ready;
  assign o_valid                 = chain_valid[NUM_STAGES];
  assign o_data                  = chain_data[NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_skid_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_flush(i_flush),
      .i_valid(chain_valid[g]),
      .o_ready(chain_ready[g]),
      .i_data (chain_data[g]),
      .o_valid(chain_valid[g+1]),
      .i_ready(chain_ready[g+1]),
      .o_data (chain_data[g+1])
    );
  end

  assign up_fire = i_valid && o_ready;
  assign dn_fire = o_valid && i_ready;
  assign o_count = count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_flush) begin
      count_q <= '0;
    end else if (up_fire && !dn_fire && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end else if (dn_fire && !up_fire && (count_q != '0)) begin
      count_q <= count_q - CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: table-driven streaming vectors,
// a queue scoreboard for random traffic, and directed reset/flush/sweep cases.
module tb_pipe_reg_chain;

  logic        clk;
  logic        i_rst;
  logic        i_flush;
  logic        i_valid, i_ready;
  logic [31:0] i_data;
  logic        o_valid, o_ready;
  logic [31:0] o_data;
  logic [2:0]  o_count;

  logic       sv_valid, sv_ready;
  logic [7:0] sv_data;
  logic       b_valid, b_ready, c_valid, c_ready;
  logic [7:0] b_data, c_data;
  logic [1:0] b_count;
  logic [4:0] c_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int ref_cnt  = 0;
  int accepted = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    logic [2:0]  ec;
  } vec_t;
  vec_t tbl[10];

  pipe_reg_chain #(.DATA_WIDTH(32), .NUM_STAGES(2), .RESET_VALUE(32'h0)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count)
  );

  pipe_reg_chain #(.DATA_WIDTH(8), .NUM_STAGES(1), .RESET_VALUE(8'h5A)) u_dut_n1 (
    .i_clk(clk), .i_rst(i_rst), .i_flush(1'b0),
    .i_valid(sv_valid), .o_ready(b_ready), .i_data(sv_data),
    .o_valid(b_valid), .i_ready(sv_ready), .o_data(b_data), .o_count(b_count)
  );

  pipe_reg_chain #(.DATA_WIDTH(8), .NUM_STAGES(8), .RESET_VALUE(8'h5A)) u_dut_n8 (
    .i_clk(clk), .i_rst(i_rst), .i_flush(1'b0),
    .i_valid(sv_valid), .o_ready(c_ready), .i_data(sv_data),
    .o_valid(c_valid), .i_ready(sv_ready), .o_data(c_data), .o_count(c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with scoreboard bookkeeping on the pre-edge handshake values.
  task automatic tick();
    logic [31:0] w;
    if (o_valid && i_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_data", 64'(o_data), 64'(w));
        ref_cnt--;
      end
    end
    if (i_valid && o_ready) begin
      exp_q.push_back(i_data);
      ref_cnt++;
      accepted++;
    end
    if (i_flush) begin
      exp_q.delete();
      ref_cnt = 0;
    end
    @(posedge clk);
    #1;
    chk("sb_count", 64'(o_count), 64'(ref_cnt));
  endtask

  initial begin
    int base;
    int cyc;
    int lat_b, lat_c, last_b, last_c, b_idx, c_idx;

    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h00, 1'b1, 3'd1};
    tbl[1] = '{1'b1, 32'h12, 1'b1, 1'b1, 32'h11, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 32'h13, 1'b1, 1'b1, 32'h12, 1'b1, 3'd2};
    tbl[3] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h13, 1'b1, 3'd2};
    tbl[4] = '{1'b1, 32'h15, 1'b1, 1'b1, 32'h14, 1'b1, 3'd2};
    tbl[5] = '{1'b1, 32'h16, 1'b1, 1'b1, 32'h15, 1'b1, 3'd2};
    tbl[6] = '{1'b1, 32'h17, 1'b1, 1'b1, 32'h16, 1'b1, 3'd2};
    tbl[7] = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h17, 1'b1, 3'd2};
    tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h18, 1'b1, 3'd1};
    tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 3'd0};

    void'($urandom(32'd2024));
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    sv_valid = 1'b0; sv_ready = 1'b1; sv_data = '0;

    // Power-on reset state
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_data",  64'(o_data),  64'd0);
    chk("rst_n1_data", 64'(b_data), 64'h5A);
    chk("rst_n8_data", 64'(c_data), 64'h5A);
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming vectors, NUM_STAGES=2
    for (int i = 0; i < 10; i++) begin
      i_valid = tbl[i].v;
      i_data  = tbl[i].d;
      i_ready = tbl[i].r;
      @(posedge clk);
      #1;
      chk("stream_valid", 64'(o_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("stream_data", 64'(o_data), 64'(tbl[i].ed));
      chk("stream_ready", 64'(o_ready), 64'(tbl[i].er));
      chk("stream_count", 64'(o_count), 64'(tbl[i].ec));
    end

    // Asynchronous reset mid-cycle with three words held
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = 32'hC0 + 32'(k);
      tick();
    end
    i_valid = 1'b0;
    chk("mid_count_before", 64'(o_count), 64'd3);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_count", 64'(o_count), 64'd0);
    chk("mid_rst_data",  64'(o_data),  64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    exp_q.delete();
    ref_cnt = 0;
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure fill: capacity is 4 words
    base = accepted;
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_data  = 32'hA0 + 32'(k);
      tick();
    end
    i_valid = 1'b0;
    chk("fill_accepted", 64'(accepted - base), 64'd4);
    chk("fill_ready",    64'(o_ready), 64'd0);
    chk("fill_count",    64'(o_count), 64'd4);
    chk("fill_data",     64'(o_data),  64'hA0);
    chk("fill_valid",    64'(o_valid), 64'd1);
    i_ready = 1'b1;
    cyc = 0;
    while (!o_ready && cyc < 4) begin
      tick();
      cyc++;
    end
    chk("ready_return", 64'(o_ready), 64'd1);

    // Random traffic: 1000 more words against the scoreboard
    base = accepted;
    cyc = 0;
    while ((accepted - base) < 1000 && cyc < 20000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = $urandom();
      i_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    chk("rand_accepted", 64'(accepted - base), 64'd1000);
    i_valid = 1'b0;
    i_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("rand_idle_valid", 64'(o_valid), 64'd0);

    // Flush with a simultaneous upstream word
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = 32'hB0 + 32'(k);
      tick();
    end
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'hDEAD;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("flush_no_dead", 64'(o_data == 32'hDEAD), 64'd0);
      tick();
    end

    // Parameter sweep: NUM_STAGES=1 and 8, DATA_WIDTH=8, RESET_VALUE=0x5A
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    chk("sweep_rst_n1_data", 64'(b_data), 64'h5A);
    chk("sweep_rst_n8_data", 64'(c_data), 64'h5A);
    chk("sweep_rst_n8_valid", 64'(c_valid), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    lat_b = 0; lat_c = 0; last_b = 0; last_c = 0; b_idx = 0; c_idx = 0;
    for (int e = 1; e <= 20; e++) begin
      sv_valid = (e <= 8);
      sv_data  = 8'(8'h10 + e);
      @(posedge clk);
      #1;
      if (b_valid) begin
        if (lat_b == 0) lat_b = e;
        last_b = e;
        chk("sweep_n1_data", 64'(b_data), 64'(8'h11 + b_idx));
        b_idx++;
      end
      if (c_valid) begin
        if (lat_c == 0) lat_c = e;
        last_c = e;
        chk("sweep_n8_data", 64'(c_data), 64'(8'h11 + c_idx));
        c_idx++;
      end
    end
    sv_valid = 1'b0;
    chk("sweep_n1_latency", 64'(lat_b), 64'd1);
    chk("sweep_n8_latency", 64'(lat_c), 64'd8);
    chk("sweep_n1_words",   64'(b_idx), 64'd8);
    chk("sweep_n8_words",   64'(c_idx), 64'd8);
    chk("sweep_n1_span",    64'(last_b - lat_b), 64'd7);
    chk("sweep_n8_span",    64'(last_c - lat_c), 64'd7);
    chk("sweep_n8_count",   64'(c_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
